tick_monitor: RTL and testbench
===============================

# tick_monitor

Receive-side checker for periodic single-cycle tick pulses produced by the team's clock-tick generators. Measures the clock-cycle interval between consecutive ticks and flags early, late or missing ticks. Declares lock after a run of in-tolerance intervals. Sits downstream of any tick source (0.1 s / 1 s / 10 s timebases) as a health monitor feeding status LEDs or a supervisor.

## Interface
- M, 5: expected tick interval in clock cycles.
- N, 3: counter width. The required relation is 2**N > M+TOL.
- TOL, 0: allowed deviation in cycles; an interval is good when M-TOL ≤ interval ≤ M+TOL.
- LOCK_CNT, 3: consecutive good intervals required to enter LOCKED.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tick  input  1  single-cycle tick pulse from the tick source.
- period  output  N  last measured interval; holds between measurements.
- period_valid  output  1  one-cycle strobe; period updated this cycle.
- early  output  1  one-cycle strobe with period_valid; interval < M-TOL.
- late  output  1  one-cycle strobe with period_valid; interval > M+TOL (only reachable when TOL makes M+TOL+1 unreachable; see timeout).
- timeout  output  1  one-cycle strobe; no tick within M+TOL cycles.
- locked  output  1  high while in LOCKED.
- err_cnt  output  8  saturating count of early + late + timeout events.

## Operation
- States: IDLE, ACQUIRE, LOCKED. Reset state is IDLE. All outputs are reset to 0.
- Interval counter cnt (N bits):
  - In IDLE it is held at 0.
  - On a sampled tick, the next value is 1.
  - Otherwise it increments.
  - At a tick, cnt equals the interval in cycles since the previous tick.
- IDLE:
  - A tick moves the block to ACQUIRE, clears the good-run counter, and loads cnt to 1.
  - No period_valid is generated for the first tick.
- ACQUIRE on a tick:
  - period ← cnt and period_valid is raised.
  - If the interval is good, good_run increments. When it reaches LOCK_CNT, the block moves to LOCKED.
  - If the interval is bad, early or late is raised, good_run ← 0, err_cnt increments, and the block stays in ACQUIRE.
- LOCKED on a tick:
  - A good interval stays in LOCKED.
  - A bad interval raises early or late, increments err_cnt, moves to ACQUIRE and clears good_run.
- Timeout (ACQUIRE or LOCKED):
  - Condition: cnt == M+TOL with no tick in that cycle.
  - Result: timeout is raised next cycle, err_cnt increments, the block returns to IDLE and cnt ← 0.
  - The next tick after a timeout is treated as a first tick.
- Simultaneous tick and timeout threshold: the tick wins. The interval M+TOL is measured as good and no timeout is raised.
- late therefore fires only if cnt reaches beyond M+TOL, which the timeout prevents. late is retained for TOL-free builds as a defensive check and must never assert in normal operation.
- err_cnt holds at 255 and never wraps.
- period_valid, early, late and timeout are cleared every cycle unless set.

## Timing
- All outputs are registered.
- A tick sampled at edge k produces period, period_valid, early and late in cycle k+1.
- State is registered, so locked changes in cycle k+1 after the qualifying tick.
- After a tick at cycle t with no further tick, timeout is high in cycle t+M+TOL+1 only.
- Asynchronous reset mid-operation: all registers clear immediately, and the first tick after deassertion is treated as a first tick.
- A tick asserted during reset is ignored.

## Structure
- Shared package tick_pkg holds:
  - the state typedef (IDLE, ACQUIRE, LOCKED);
  - the err_cnt width constant (8).
- One sub-module, tick_interval_counter, is natural. It is the N-bit counter with load-to-1 on tick, clear in IDLE, and an at_limit output for cnt == M+TOL.
- The FSM, checks and err_cnt live in tick_monitor.

## Test plan
All scenarios use M=5, TOL=0, LOCK_CNT=3.
- Lock acquisition: reset released, then ticks at cycles 2, 7, 12, 17. Required: period_valid with period=5 in cycles 8, 13, 18; locked=1 from cycle 18; err_cnt=0.
- Early tick: while locked, tick 4 cycles after the previous tick. Required: next cycle shows period=4, period_valid=1, early=1; locked drops to 0; err_cnt=1; then 3 good intervals relock.
- Missing tick: last tick at cycle t, then tick held low. Required: timeout=1 only in cycle t+6; locked=0; err_cnt increments by 1; a tick at t+8 produces no period_valid.
- Boundary: TOL=1 build, intervals 4, 6, 5 while acquiring. Required: all good, no early or late, locked after the third.
- Reset mid-lock: assert reset for 1 cycle while locked and err_cnt=2. Required: all outputs 0 immediately, and relock needs a first tick plus 3 good intervals.
- Saturation: 300 consecutive intervals of 3. Required: err_cnt stops at 255 and never wraps; early pulses on every measurement.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types and constants for the tick monitor.
package tick_pkg;

  // Lock-tracking FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } tick_state_e;

  // Width of the saturating error counter.
  localparam int unsigned ErrCntW = 8;

endpackage

// File: rtl/tick_interval_counter.sv
// Counts clock cycles since the last tick. Restarts at 1 on every tick so that
// the value seen alongside a tick is the interval from the previous tick.
module tick_interval_counter #(
  parameter int unsigned M   = 5,
  parameter int unsigned N   = 3,
  parameter int unsigned TOL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         clear_i,
  output logic [N-1:0] cnt_o,
  output logic         at_limit_o
);

  localparam logic [N-1:0] Limit = N'(M + TOL);

  logic [N-1:0] cnt_d, cnt_q;

  // Next count: tick restarts at 1, clear holds at 0, otherwise count up.
  always_comb begin
    cnt_d = cnt_q + N'(1);
    if (tick_i) begin
      cnt_d = N'(1);
    end else if (clear_i) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/tick_monitor.sv
// Health monitor for a periodic tick: measures tick-to-tick intervals, flags
// early/late/missing ticks, tracks lock and counts errors (saturating).
module tick_monitor
  import tick_pkg::*;
#(
  parameter int unsigned M        = 5,
  parameter int unsigned N        = 3,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  output logic [N-1:0]       period,
  output logic               period_valid,
  output logic               early,
  output logic               late,
  output logic               timeout,
  output logic               locked,
  output logic [ErrCntW-1:0] err_cnt
);

  localparam int unsigned      GoodW      = $clog2(LOCK_CNT + 1);
  localparam logic [N-1:0]     LoBound    = N'(M - TOL);
  localparam logic [N-1:0]     HiBound    = N'(M + TOL);
  localparam logic [GoodW-1:0] LockTarget = GoodW'(LOCK_CNT);

  tick_state_e         state_d, state_q;
  logic [GoodW-1:0]    good_d, good_q;
  logic [N-1:0]        period_d, period_q;
  logic                pv_d, pv_q;
  logic                early_d, early_q;
  logic                late_d, late_q;
  logic                timeout_d, timeout_q;
  logic                locked_d, locked_q;
  logic [ErrCntW-1:0]  err_d, err_q;
  logic                err_event;

  logic [N-1:0]        cnt;
  logic                at_limit;
  logic                cnt_clear;
  logic                is_early;
  logic                is_good;

  // Counter is parked at 0 while idle and cleared on the timeout that sends us there.
  assign cnt_clear = (state_q == StIdle) || timeout_d;

  tick_interval_counter #(
    .M   (M),
    .N   (N),
    .TOL (TOL)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (reset),
    .tick_i     (tick),
    .clear_i    (cnt_clear),
    .cnt_o      (cnt),
    .at_limit_o (at_limit)
  );

  assign is_early = (cnt < LoBound);
  assign is_good  = !is_early && (cnt <= HiBound);

  // Next-state, interval checks and strobe generation.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    early_d   = 1'b0;
    late_d    = 1'b0;
    timeout_d = 1'b0;
    err_event = 1'b0;

    case (state_q)
      StIdle: begin
        // First tick only starts the measurement; no interval yet.
        if (tick) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      StAcquire, StLocked: begin
        if (tick) begin
          // A tick on the limit cycle wins over the timeout.
          period_d = cnt;
          pv_d     = 1'b1;
          if (is_good) begin
            if (state_q == StAcquire) begin
              good_d = good_q + GoodW'(1);
              if (good_d == LockTarget) begin
                state_d = StLocked;
              end
            end
          end else begin
            early_d   = is_early;
            late_d    = !is_early;
            err_event = 1'b1;
            good_d    = '0;
            state_d   = StAcquire;
          end
        end else if (at_limit) begin
          timeout_d = 1'b1;
          err_event = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    err_d    = (err_event && (err_q != '1)) ? err_q + ErrCntW'(1) : err_q;
    locked_d = (state_d == StLocked);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      good_q    <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      early_q   <= early_d;
      late_q    <= late_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign early        = early_q;
  assign late         = late_q;
  assign timeout      = timeout_q;
  assign locked       = locked_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench: stimulus pushes hand-computed responses, monitors pop and
// compare whenever a DUT raises a strobe. DUT a: M=5 TOL=0; DUT b: M=5 TOL=1.
module tb_tick_monitor;

  typedef struct {
    int         id;
    logic [2:0] per;
    logic       pv;
    logic       early;
    logic       to;
    logic       lk;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_a = 1'b0;
  logic       tick_b = 1'b0;

  logic [2:0] a_period, b_period;
  logic       a_pv, a_early, a_late, a_to, a_lk;
  logic       b_pv, b_early, b_late, b_to, b_lk;
  logic [7:0] a_err, b_err;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_push = 0;

  always #5 clk = ~clk;

  tick_monitor #(.M(5), .N(3), .TOL(0), .LOCK_CNT(3)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick_a),
    .period       (a_period),
    .period_valid (a_pv),
    .early        (a_early),
    .late         (a_late),
    .timeout      (a_to),
    .locked       (a_lk),
    .err_cnt      (a_err)
  );

  tick_monitor #(.M(5), .N(3), .TOL(1), .LOCK_CNT(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick_b),
    .period       (b_period),
    .period_valid (b_pv),
    .early        (b_early),
    .late         (b_late),
    .timeout      (b_to),
    .locked       (b_lk),
    .err_cnt      (b_err)
  );

  task automatic check_rsp(input string nm, input exp_t e, input logic [2:0] per,
                           input logic pv, input logic ea, input logic la, input logic to,
                           input logic lk, input logic [7:0] err);
    n_vec++;
    if (per !== e.per || pv !== e.pv || ea !== e.early || la !== 1'b0 || to !== e.to ||
        lk !== e.lk || err !== e.err) begin
      n_bad++;
      $display("FAIL %s #%0d: got period=%0d pv=%b early=%b late=%b timeout=%b locked=%b err=%0d; want period=%0d pv=%b early=%b late=0 timeout=%b locked=%b err=%0d",
               nm, e.id, per, pv, ea, la, to, lk, err, e.per, e.pv, e.early, e.to, e.lk, e.err);
    end
  endtask

  task automatic mon_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (a_pv || a_early || a_late || a_to)) begin
        if (q_a.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL a_unexpected: got pv=%b early=%b late=%b timeout=%b, want no strobe",
                   a_pv, a_early, a_late, a_to);
        end else begin
          e = q_a.pop_front();
          check_rsp("a_rsp", e, a_period, a_pv, a_early, a_late, a_to, a_lk, a_err);
        end
      end
    end
  endtask

  task automatic mon_b();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (b_pv || b_early || b_late || b_to)) begin
        if (q_b.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL b_unexpected: got pv=%b early=%b late=%b timeout=%b, want no strobe",
                   b_pv, b_early, b_late, b_to);
        end else begin
          e = q_b.pop_front();
          check_rsp("b_rsp", e, b_period, b_pv, b_early, b_late, b_to, b_lk, b_err);
        end
      end
    end
  endtask

  task automatic push(input bit sel_b, input int per, input bit pv, input bit ea,
                      input bit to, input bit lk, input int err);
    exp_t e;
    e.id    = n_push++;
    e.per   = 3'(per);
    e.pv    = pv;
    e.early = ea;
    e.to    = to;
    e.lk    = lk;
    e.err   = 8'(err);
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  // Tick raised `gap` cycles after the previous one; optional expected measurement.
  task automatic step(input bit sel_b, input int gap, input bit rsp, input int per,
                      input bit ea, input bit lk, input int err);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (sel_b) tick_b = (i == gap - 1);
      else       tick_a = (i == gap - 1);
    end
    if (rsp) push(sel_b, per, 1'b1, ea, 1'b0, lk, err);
  endtask

  task automatic expect_timeout(input bit sel_b, input int per, input int err);
    push(sel_b, per, 1'b0, 1'b0, 1'b1, 1'b0, err);
  endtask

  task automatic check_zero(input string nm);
    n_vec++;
    if ({a_period, a_pv, a_early, a_late, a_to, a_lk, a_err} !== '0 ||
        {b_period, b_pv, b_early, b_late, b_to, b_lk, b_err} !== '0) begin
      n_bad++;
      $display("FAIL %s: got a=%h b=%h, want all outputs 0", nm,
               {a_period, a_pv, a_early, a_late, a_to, a_lk, a_err},
               {b_period, b_pv, b_early, b_late, b_to, b_lk, b_err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      mon_a();
      mon_b();
    join_none

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // TOL=1 boundary: 4, 6 (tick on the limit cycle), 5 all good; then lost tick.
    step(1'b1, 2, 1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b1, 4, 1'b1, 4, 1'b0, 1'b0, 0);
    step(1'b1, 6, 1'b1, 6, 1'b0, 1'b0, 0);
    step(1'b1, 5, 1'b1, 5, 1'b0, 1'b1, 0);
    expect_timeout(1'b1, 5, 1);
    @(negedge clk);
    tick_b = 1'b0;
    repeat (10) @(negedge clk);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Lock acquisition: ticks at cycles 2, 7, 12, 17.
    step(1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b1, 0);
    // Early tick while locked, then relock.
    step(1'b0, 4, 1'b1, 4, 1'b1, 1'b0, 1);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 1);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 1);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b1, 1);
    // Missing tick: timeout at t+6, tick at t+8 is a first tick.
    expect_timeout(1'b0, 5, 2);
    step(1'b0, 8, 1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 2);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 2);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b1, 2);

    @(negedge clk);
    tick_a = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_lk !== 1'b1 || a_err !== 8'd2) begin
      n_bad++;
      $display("FAIL pre_reset: got locked=%b err=%0d, want locked=1 err=2", a_lk, a_err);
    end

    // Reset mid-lock, tick held high during reset must be ignored.
    reset  = 1'b1;
    tick_a = 1'b1;
    #1;
    check_zero("mid_lock_reset");
    @(negedge clk);
    reset  = 1'b0;
    tick_a = 1'b0;

    step(1'b0, 3, 1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b0, 0);
    step(1'b0, 5, 1'b1, 5, 1'b0, 1'b1, 0);

    // Saturation: 300 early intervals of 3.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 3, 1'b1, 3, 1'b1, 1'b0, (i + 1 > 255) ? 255 : i + 1);
    end
    @(negedge clk);
    tick_a = 1'b0;

    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d responses outstanding, want 0/0", q_a.size(),
               q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
